// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM stage and a word-write DataMemory.
// Big-endian lane extraction on loads; sub-word stores use read-modify-write.
module load_store_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              resp_valid,
   output logic [31:0]       rdata,
   output logic              fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata
);
   localparam int unsigned DATA_W = 32;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_BAD  = 2'b11;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsuState;

   lsuState     state;
   logic [3:0]  opReg;
   logic [1:0]  offsetReg;
   logic [15:0] storeData;

   logic              reqFault;
   logic [4:0]        byteShift;
   logic [4:0]        halfShift;
   logic [7:0]        byteLane;
   logic [15:0]       halfLane;
   logic [DATA_W-1:0] loadValue;
   logic [DATA_W-1:0] mergedWord;

   assign reqFault = (op[1:0] == SIZE_BAD)
                  || ((op[1:0] == SIZE_HALF) && addr[0])
                  || ((op[1:0] == SIZE_WORD) && (addr[1:0] != 2'b00));

   // Offset k of the big-endian word sits 8*(3-k) bits above bit 0.
   assign byteShift = {~offsetReg, 3'b000};
   assign halfShift = {~offsetReg[1], 4'b0000};
   assign byteLane  = 8'(mem_rdata >> byteShift);
   assign halfLane  = 16'(mem_rdata >> halfShift);

   always_comb begin
      loadValue = mem_rdata;
      case (opReg[1:0])
         SIZE_BYTE: loadValue = opReg[2] ? DATA_W'(byteLane) : {{24{byteLane[7]}}, byteLane};
         SIZE_HALF: loadValue = opReg[2] ? DATA_W'(halfLane) : {{16{halfLane[15]}}, halfLane};
         default:   loadValue = mem_rdata;
      endcase
   end

   always_comb begin
      mergedWord = mem_rdata;
      case (opReg[1:0])
         SIZE_BYTE: mergedWord = (mem_rdata & ~(32'h0000_00FF << byteShift))
                               | (DATA_W'(storeData[7:0]) << byteShift);
         SIZE_HALF: mergedWord = (mem_rdata & ~(32'h0000_FFFF << halfShift))
                               | (DATA_W'(storeData) << halfShift);
         default:   mergedWord = mem_rdata;
      endcase
   end

   // Outputs are registered alongside the state so they track it as Moore outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         fault      <= 1'b0;
         rdata      <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         opReg      <= '0;
         offsetReg  <= '0;
         storeData  <= '0;
      end else begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         fault      <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  opReg     <= op;
                  offsetReg <= addr[1:0];
                  storeData <= wdata[15:0];
                  mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  if (reqFault) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     fault      <= 1'b1;
                     rdata      <= '0;
                  end else if (op[3] && (op[1:0] == SIZE_WORD)) begin
                     state     <= WR;
                     mem_write <= 1'b1;
                     mem_wdata <= wdata;
                  end else begin
                     state    <= RD;
                     mem_read <= 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            RD: state <= CAP;
            CAP: begin
               if (opReg[3]) begin
                  state     <= WR;
                  mem_write <= 1'b1;
                  mem_wdata <= mergedWord;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  rdata      <= loadValue;
               end
            end
            WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_addr  <= '0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_addr  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model plus a per-cycle compare task.
module tb_load_store_unit;
   localparam int unsigned ADDR_W = 32;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_BAD = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;

   logic              clk, rst, req_valid, req_ready, resp_valid, fault, mem_read, mem_write;
   logic [3:0]        op;
   logic [ADDR_W-1:0] addr, mem_addr;
   logic [31:0]       wdata, rdata, mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic [31:0]       memArr [0:63] = '{default: '0};
   logic [31:0]       refMem [0:63];

   int vectors, miscompares;
   bit busy, expFault, isStore;
   int age, lat, expRd, expWr, rdSeen, wrSeen, respAt, commitIdx;
   logic [31:0] expRdata, respRdata, expWdata, expWordAddr, commitWord;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
      .rdata(rdata), .fault(fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DataMemory stand-in: word writes, one-cycle synchronous read.
   always @(posedge clk) begin
      if (mem_write) memArr[mem_addr[7:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= memArr[mem_addr[7:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelLoad(logic [31:0] w, logic uns, logic [1:0] sz, int unsigned k);
      int unsigned v;
      if (sz == 2'b00) begin
         v = (w >> (8 * (3 - k))) & 32'hFF;
         if (!uns && v >= 32'h80) v += 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (k >= 2) ? (w & 32'hFFFF) : (w >> 16);
         if (!uns && v >= 32'h8000) v += 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] modelStore(logic [31:0] w, logic [1:0] sz, int unsigned k, logic [31:0] d);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = 8'(w >> (8 * (3 - i)));
      if (sz == 2'b10) return d;
      if (sz == 2'b00) b[k] = d[7:0];
      else if (sz == 2'b01 && k % 2 == 0) begin
         b[k]     = d[15:8];
         b[k + 1] = d[7:0];
      end
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic accept();
      int unsigned k, idx;
      logic [1:0] sz;
      sz = op[1:0];
      k = addr[1:0];
      idx = addr[7:2];
      busy = 1; age = 1; rdSeen = 0; wrSeen = 0; respAt = -1;
      expWordAddr = {addr[31:2], 2'b00};
      isStore = op[3];
      expFault = (sz == 2'b11) || (sz == 2'b01 && k % 2 != 0) || (sz == 2'b10 && k != 0);
      commitIdx = idx;
      commitWord = modelStore(refMem[idx], sz, k, wdata);
      expWdata = commitWord;
      respRdata = expRdata;
      if (expFault) begin
         lat = 1; expRd = 0; expWr = 0; respRdata = '0;
      end else if (isStore && sz == 2'b10) begin
         lat = 2; expRd = 0; expWr = 1;
      end else if (isStore) begin
         lat = 4; expRd = 1; expWr = 1;
      end else begin
         lat = 3; expRd = 1; expWr = 0;
         respRdata = modelLoad(refMem[idx], op[2], sz, k);
      end
   endtask

   // Per-cycle comparison of every DUT output against the transaction model.
   task automatic checkCycle();
      bit respNow;
      respNow = busy && (age == lat);
      chk("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(respNow));
      chk("fault", 32'(fault), 32'(respNow && expFault));
      chk("mem_addr", mem_addr, busy ? expWordAddr : 32'd0);
      if (respNow) expRdata = respRdata;
      chk("rdata", rdata, expRdata);
      if (busy) begin
         if (mem_read) rdSeen++;
         if (mem_write) begin
            wrSeen++;
            chk("mem_wdata", mem_wdata, expWdata);
         end
         if (resp_valid) respAt = age;
      end
      if (respNow) begin
         chk("read_cycles", rdSeen, expRd);
         chk("write_cycles", wrSeen, expWr);
         if (isStore && !expFault) refMem[commitIdx] = commitWord;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (busy) begin
         if (age == lat) busy = 0;
         else age++;
      end else if (req_valid && !rst) begin
         accept();
      end
      @(negedge clk);
      checkCycle();
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, input int expLat);
      op = o; addr = a; wdata = d; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      while (busy) step();
      chk("latency", respAt, expLat);
      chk("mem_word", memArr[commitIdx], refMem[commitIdx]);
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready), 32'd1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_fault"},      32'(fault), 32'd0);
      chk({tag, "_rdata"},      rdata, 32'd0);
      chk({tag, "_mem_read"},   32'(mem_read), 32'd0);
      chk({tag, "_mem_write"},  32'(mem_write), 32'd0);
      chk({tag, "_mem_addr"},   mem_addr, 32'd0);
      chk({tag, "_mem_wdata"},  mem_wdata, 32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      busy = 0; age = 0; lat = 0; expRdata = '0; respAt = -1;
      expFault = 0; isStore = 0; expRd = 0; expWr = 0; rdSeen = 0; wrSeen = 0;
      commitIdx = 0; commitWord = '0; respRdata = '0; expWdata = '0; expWordAddr = '0;
      for (int i = 0; i < 64; i++) refMem[i] = '0;
      rst = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;

      @(negedge clk);
      checkResetValues("por");
      step();
      rst = 1'b0;
      step();

      // Reset asserted mid-cycle while the load sits in RD.
      op = OP_LW; addr = 32'h14; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rd_before_reset", 32'(mem_read), 32'd1);
      #2 rst = 1'b1;
      #1 checkResetValues("rst_rd");
      busy = 0; expRdata = '0;
      step();
      rst = 1'b0;
      step();
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      // Word round trip.
      issue(OP_SW, 32'h14, 32'h0000_0032, 2);
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("lw_roundtrip", rdata, 32'h0000_0032);

      // Byte store into a known word, then loads.
      issue(OP_SW, 32'h14, 32'h1122_3344, 2);
      issue(OP_SB, 32'h15, 32'h0000_0080, 4);
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("lw_after_sb", rdata, 32'h1180_3344);
      issue(OP_LB, 32'h15, 32'h0, 3);
      chk("lb_signed", rdata, 32'hFFFF_FF80);
      issue(OP_LBU, 32'h15, 32'h0, 3);
      chk("lbu", rdata, 32'h0000_0080);

      // Halfword store (upper wdata bits must be ignored), then loads.
      issue(OP_SH, 32'h16, 32'h1234_BEEF, 4);
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("lw_after_sh", rdata, 32'h1180_BEEF);
      issue(OP_LH, 32'h16, 32'h0, 3);
      chk("lh_signed", rdata, 32'hFFFF_BEEF);
      issue(OP_LHU, 32'h16, 32'h0, 3);
      chk("lhu", rdata, 32'h0000_BEEF);

      // Faulting requests.
      issue(OP_LW, 32'h15, 32'h0, 1);
      chk("fault_lw_rdata", rdata, 32'h0);
      issue(OP_SH, 32'h17, 32'hFFFF_FFFF, 1);
      issue(OP_BAD, 32'h14, 32'h0, 1);
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("mem_after_faults", rdata, 32'h1180_BEEF);

      // Busy hold then abort in WR: no second acceptance, no memory update.
      op = OP_SB; addr = 32'h14; wdata = 32'h0000_0055; req_valid = 1'b1;
      step();
      step();
      step();
      chk("abort_in_wr", 32'(mem_write), 32'd1);
      #2 rst = 1'b1;
      #1 checkResetValues("rst_wr");
      busy = 0; expRdata = '0; req_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("mem_after_abort", rdata, 32'h1180_BEEF);

      // Remaining lanes and positive sign extension.
      issue(OP_SB, 32'h17, 32'h0000_00A5, 4);
      issue(OP_LW, 32'h14, 32'h0, 3);
      chk("lw_after_sb3", rdata, 32'h1180_BEA5);
      issue(OP_LB, 32'h14, 32'h0, 3);
      chk("lb_offset0", rdata, 32'h0000_0011);
      issue(OP_LH, 32'h14, 32'h0, 3);
      chk("lh_offset0", rdata, 32'h0000_1180);
      issue(OP_LBU, 32'h17, 32'h0, 3);
      chk("lbu_offset3", rdata, 32'h0000_00A5);
      issue(OP_SW, 32'h20, 32'hCAFE_F00D, 2);
      issue(OP_LW, 32'h20, 32'h0, 3);
      chk("lw_other_word", rdata, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the EX/MEM pipeline stage and `DataMemory`, which is word-wide for writes. Accepts one byte/halfword/word load or store per handshake. Loads are extracted and sign- or zero-extended from the big-endian memory word. Sub-word stores are done as a read-modify-write, and misaligned or illegal accesses are flagged without touching memory.

## Interface
- `ADDR_W`, default 32: width of the address.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request strobe from the EX/MEM stage.
- `req_ready` out 1: high only in IDLE. A request is accepted on a rising edge where `req_valid && req_ready`.
- `op` in 4: `op[3]` is 1 for store, 0 for load. `op[2]` is unsigned (loads only). `op[1:0]` is size: 00 byte, 01 half, 10 word, 11 illegal.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result. Registered and held until the next response.
- `fault` out 1: misaligned/illegal indication. Valid with `resp_valid`.
- `mem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata` out 32: merged word to memory.
- `mem_read` out 1, `mem_write` out 1: memory strobes.
- `mem_rdata` in 32: memory word. Valid in the cycle after a cycle with `mem_read=1`.

## Operation
- On acceptance, latch `op`, `addr` and `wdata`.
- Byte lanes are big-endian: offset k occupies bits `[31-8k -: 8]`. Half at offset 0 is `[31:16]`; at offset 2 it is `[15:0]`.
- Fault condition: `op[1:0]=11`, or half with `addr[0]=1`, or word with `addr[1:0]!=0`.
- FSM states and outputs:
  - IDLE: `req_ready=1`.
  - RD: `mem_read=1`.
  - CAP: capture `mem_rdata` into the word buffer.
  - WR: `mem_write=1`, `mem_wdata` = buffer with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`. For a word store, `mem_wdata=wdata`.
  - RESP: `resp_valid=1`.
- Transitions:
  - IDLE → RESP on a faulting request.
  - IDLE → WR on a word store.
  - IDLE → RD on any load or sub-word store.
  - RD → CAP unconditionally.
  - CAP → RESP for a load; CAP → WR for a store.
  - WR → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Load result:
  - Byte or half is sign-extended if `op[2]=0`, zero-extended if `op[2]=1`.
  - Word ignores `op[2]`.
  - `rdata` is updated on entering RESP.
- Store response: `rdata` is unchanged.
- Fault response: `rdata=0`, `fault=1`, and no memory strobe is ever asserted.
- `mem_addr` is driven from the latched address in every non-IDLE state and is 0 in IDLE.
- `req_valid` is ignored while not in IDLE; there is no queuing.
- The next request may be accepted on the edge that leaves RESP→IDLE +1, i.e. in the cycle after RESP.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `fault=0`, `rdata=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
- Reset takes effect immediately and asynchronously; all strobes drop in the same cycle.
- Latency from the accepting edge to the cycle in which `resp_valid=1`:
  - fault: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Throughput, including the mandatory IDLE cycle: one request per latency+1 cycles.
- Reset mid-operation:
  - The transaction is abandoned with no response.
  - Memory is modified only if a WR-state rising edge already occurred.
  - RD/CAP progress is discarded.
- Strobes are Moore outputs of state only. `mem_read` and `mem_write` are never high in the same cycle.

## Test plan
- **Reset:** assert `rst` mid-cycle while in RD.
  - Outputs go immediately to the reset values listed above.
  - After release, `req_ready=1`.
- **Word round trip:** SW `addr=0x14`, `wdata=0x00000032`, then LW `0x14`.
  - Store `resp_valid` at cycle 2; `mem_write` for exactly 1 cycle.
  - Load `resp_valid` at cycle 3 with `rdata=0x00000032`, `fault=0`.
- **Byte store and loads:** SW `0x11223344` at `0x14`; SB `0x80` at `0x15`.
  - Then LW `0x14` gives `0x11803344`.
  - LB `0x15` gives `0xFFFFFF80`.
  - LBU `0x15` gives `0x00000080`.
- **Halfword store and loads:** SH `0xBEEF` at `0x16` (resp at cycle 4).
  - Then LW `0x14` gives `0x1180BEEF`.
  - LH `0x16` gives `0xFFFFBEEF`.
  - LHU `0x16` gives `0x0000BEEF`.
- **Faults:** LW `0x15`, SH `0x17`, and `op[1:0]=11`.
  - Each gives `resp_valid` at cycle 1 with `fault=1`, `rdata=0`.
  - `mem_read` and `mem_write` stay 0 throughout.
  - Memory word at `0x14` is unchanged.
- **Busy and abort:** hold `req_valid=1` during an SB, then assert `rst` during its WR state.
  - No second acceptance occurs while busy.
  - `mem_write` drops asynchronously and no `resp_valid` is produced.
